ica_centering: RTL and testbench

//  Frame-based mean-removal stage directly upstream of fast_ica; FastICA needs zero-mean observations.

---
 rtl/ica_pkg.sv | 22 ++
 rtl/ica_sample_buffer.sv | 33 +++
 rtl/ica_centering.sv | 154 +++++++++++++++
 tb/tb_ica_centering.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ica_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ica_pkg : shared types, defaults and FSM encoding for ica_centering         |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package ica_pkg;

  localparam int DEF_SIZE_N = 8;
  localparam int DEF_SIZE_M = 512;
  localparam int DEF_DATA_W = 16;
  localparam int ADDR_W     = $clog2(DEF_SIZE_M);

  typedef logic signed [DEF_DATA_W-1:0] sample_t;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    MEAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ica_sample_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ica_sample_buffer : simple dual-port frame RAM, 1-cycle registered read     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module ica_sample_buffer
  import ica_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int WIDTH = 128
) (
  input  logic                     clk,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [WIDTH-1:0]         rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // No reset on the array or read register so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/ica_centering.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ica_centering : buffers a frame, computes per-channel means, streams it     |
// | back mean-removed. ICA_CENTER_SAT_EN selects saturation instead of wrap.    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module ica_centering
  import ica_pkg::*;
#(
  parameter int SIZE_N = DEF_SIZE_N,
  parameter int SIZE_M = DEF_SIZE_M,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SIZE_N*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SIZE_N*DATA_W-1:0] out_data,
  output logic                     out_last,
  output logic                     busy
);

  localparam int LOG2_M = $clog2(SIZE_M);
  localparam int ACC_W  = DATA_W + LOG2_M;
  localparam int VEC_W  = SIZE_N * DATA_W;
  localparam logic [LOG2_M:0] RD_END = (LOG2_M+1)'(SIZE_M);

  state_t state_q, state_d;

  logic                           ready_q;
  logic [LOG2_M-1:0]              wr_idx_q;
  logic [LOG2_M:0]                rd_idx_q;
  logic                           s1_valid_q;
  logic                           s1_last_q;
  logic                           out_valid_q;
  logic                           out_last_q;
  logic [VEC_W-1:0]               out_data_q;
  logic [SIZE_N-1:0][ACC_W-1:0]   acc_q;
  logic [SIZE_N-1:0][DATA_W-1:0]  mean_q;

  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_s1_move;
  logic             w_rd_issue;
  logic [VEC_W-1:0] w_rd_data;
  logic [VEC_W-1:0] w_diff;

  assign w_in_fire  = in_valid && ready_q;
  assign w_out_fire = out_valid_q && out_ready;
  assign w_s1_move  = s1_valid_q && (!out_valid_q || out_ready);
  // RAM output acts as a prefetch stage: read ahead whenever it is empty or draining.
  assign w_rd_issue = (state_q == DRAIN) && (rd_idx_q != RD_END) &&
                      (!s1_valid_q || w_s1_move);

  ica_sample_buffer #(
    .DEPTH (SIZE_M),
    .WIDTH (VEC_W)
  ) u_buf (
    .clk       (clk),
    .wr_en_i   (w_in_fire),
    .wr_addr_i (wr_idx_q),
    .wr_data_i (in_data),
    .rd_en_i   (w_rd_issue),
    .rd_addr_i (rd_idx_q[LOG2_M-1:0]),
    .rd_data_o (w_rd_data)
  );

  for (genvar c = 0; c < SIZE_N; c++) begin : g_chan
`ifdef ICA_CENTER_SAT_EN
    logic [DATA_W:0] w_wide;
    assign w_wide = {w_rd_data[c*DATA_W+DATA_W-1], w_rd_data[c*DATA_W +: DATA_W]} -
                    {mean_q[c][DATA_W-1], mean_q[c]};
    assign w_diff[c*DATA_W +: DATA_W] = (w_wide[DATA_W] != w_wide[DATA_W-1]) ?
                    {w_wide[DATA_W], {(DATA_W-1){~w_wide[DATA_W]}}} : w_wide[DATA_W-1:0];
`else
    assign w_diff[c*DATA_W +: DATA_W] = w_rd_data[c*DATA_W +: DATA_W] - mean_q[c];
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (w_in_fire && (wr_idx_q == '1)) state_d = MEAN;
      MEAN:    state_d = DRAIN;
      DRAIN:   if (w_out_fire && out_last_q) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == LOAD);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      acc_q       <= '0;
      mean_q      <= '0;
    end else begin
      if (w_in_fire) begin
        wr_idx_q <= wr_idx_q + 1'b1;
        for (int c = 0; c < SIZE_N; c++) begin
          acc_q[c] <= acc_q[c] + {{LOG2_M{in_data[c*DATA_W+DATA_W-1]}}, in_data[c*DATA_W +: DATA_W]};
        end
      end
      // Dropping the low LOG2_M bits of the signed sum is a floor divide by SIZE_M.
      if (state_q == MEAN) begin
        for (int c = 0; c < SIZE_N; c++) begin
          mean_q[c] <= acc_q[c][ACC_W-1:LOG2_M];
        end
        acc_q <= '0;
      end
      if (w_rd_issue) begin
        rd_idx_q   <= rd_idx_q + 1'b1;
        s1_valid_q <= 1'b1;
        s1_last_q  <= (rd_idx_q[LOG2_M-1:0] == '1);
      end else if (w_s1_move) begin
        s1_valid_q <= 1'b0;
      end
      if (w_s1_move) begin
        out_valid_q <= 1'b1;
        out_data_q  <= w_diff;
        out_last_q  <= s1_last_q;
      end else if (w_out_fire) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
      if (w_out_fire && out_last_q) rd_idx_q <= '0;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != LOAD);

endmodule
`default_nettype wire

// File: tb/tb_ica_centering.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ica_centering : randomized self-checking bench with a frame-level model  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_ica_centering;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Small instance: 2 channels x 4 samples
  logic        s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b1, s_out_last, s_busy;
  logic [31:0] s_in_data = '0, s_out_data;
  // Default instance: 8 channels x 512 samples
  logic         b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1, b_out_last, b_busy;
  logic [127:0] b_in_data = '0, b_out_data;

  ica_centering #(.SIZE_N(2), .SIZE_M(4), .DATA_W(16)) u_small (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_last(s_out_last), .busy(s_busy));

  ica_centering u_big (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .busy(b_busy));

  int n_vec  = 0;
  int n_miss = 0;
  int busy_ready_viol = 0;
  int fr [4][2];

  task automatic check_value(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint floor_mean(input longint sum, input int m);
    longint q = sum / m;
    if ((sum % m != 0) && (sum < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint center(input longint x, input longint mean);
    longint d = x - mean;
`ifdef ICA_CENTER_SAT_EN
    if (d > 32767)  d = 32767;
    if (d < -32768) d = -32768;
`else
    d = ((((d + 32768) % 65536) + 65536) % 65536) - 32768;
`endif
    return d;
  endfunction

  always @(negedge clk) if (s_busy && s_in_ready) busy_ready_viol++;

  task automatic set_frame(input int a0, a1, a2, a3, input int b0, b1, b2, b3);
    fr[0][0] = a0; fr[1][0] = a1; fr[2][0] = a2; fr[3][0] = a3;
    fr[0][1] = b0; fr[1][1] = b1; fr[2][1] = b2; fr[3][1] = b3;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_in_ready"},  s_in_ready,  0);
    check_value({tag, "_out_valid"}, s_out_valid, 0);
    check_value({tag, "_out_data"},  s_out_data,  0);
    check_value({tag, "_out_last"},  s_out_last,  0);
    check_value({tag, "_busy"},      s_busy,      0);
  endtask

  // Sends fr through the small DUT and checks its centered output stream.
  task automatic run_small(input bit bp, input bit gap, input bit hold);
    longint exp_v [4][2];
    for (int c = 0; c < 2; c++) begin
      longint sum = 0;
      for (int k = 0; k < 4; k++) sum += fr[k][c];
      for (int k = 0; k < 4; k++) exp_v[k][c] = center(fr[k][c], floor_mean(sum, 4));
    end
    fork
      begin
        int k = 0;
        int guard = 0;
        while (k < 4 && guard < 200) begin
          @(negedge clk);
          guard++;
          s_in_valid = gap ? ($urandom_range(0, 3) != 0) : 1'b1;
          s_in_data  = {16'(fr[k][1]), 16'(fr[k][0])};
          if (s_in_valid && s_in_ready) k++;
        end
        check_value("sent", k, 4);
        @(negedge clk);
        s_in_valid = hold;
        s_in_data  = 32'h7fff_7fff;
      end
      begin
        int idx = 0;
        int guard = 0;
        bit stalled = 0;
        logic [31:0] prev = '0;
        while (idx < 4 && guard < 400) begin
          @(negedge clk);
          guard++;
          if (stalled) begin
            check_value("stall_valid", s_out_valid, 1);
            check_value("stall_data", s_out_data, prev);
          end
          stalled = 0;
          s_out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
          if (s_out_valid) begin
            if (s_out_ready) begin
              check_value("ch0", longint'($signed(s_out_data[15:0])), exp_v[idx][0]);
              check_value("ch1", longint'($signed(s_out_data[31:16])), exp_v[idx][1]);
              check_value("last", s_out_last, (idx == 3));
              idx++;
              if (idx == 4) s_in_valid = 1'b0;
            end else begin
              stalled = 1;
              prev = s_out_data;
            end
          end
        end
        check_value("received", idx, 4);
        @(negedge clk);
        check_value("ready_after_last", s_in_ready, 1);
        s_out_ready = 1'b1;
      end
    join
  endtask

  task automatic run_big();
    fork
      begin
        int k = 0;
        int guard = 0;
        while (k < 1024 && guard < 6000) begin
          @(negedge clk);
          guard++;
          b_in_valid = 1'b1;
          for (int c = 0; c < 8; c++) b_in_data[c*16 +: 16] = 16'(c*100 + (k % 512));
          if (b_in_ready) k++;
        end
        @(negedge clk);
        b_in_valid = 1'b0;
      end
      begin
        int n = 0;
        int guard = 0;
        int idle = 0;
        while (n < 1024 && guard < 6000) begin
          @(negedge clk);
          guard++;
          if (b_busy && !b_out_valid) idle++;
          if (b_out_valid) begin
            for (int c = 0; c < 8; c++)
              check_value("big_ch", longint'($signed(b_out_data[c*16 +: 16])), (n % 512) - 255);
            check_value("big_last", b_out_last, ((n % 512) == 511));
            n++;
            if (n % 512 == 0) begin
              check_value("big_idle_le3", (idle <= 3), 1);
              idle = 0;
              @(negedge clk);
              guard++;
              check_value("big_ready_after_last", b_in_ready, 1);
            end
          end
        end
        check_value("big_count", n, 1024);
      end
    join
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    #23;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    set_frame(1, 2, 3, 6, 5, 5, 5, 5);
    run_small(0, 0, 0);
    set_frame(-1, 0, 0, 0, 0, 0, 0, 0);
    run_small(0, 0, 0);
    set_frame(32767, 32767, -32768, -32768, 0, 0, 0, 0);
    run_small(0, 0, 0);
    set_frame(1, 2, 3, 6, 5, 5, 5, 5);
    run_small(1, 0, 1);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++)
        for (int c = 0; c < 2; c++) fr[k][c] = int'($urandom_range(0, 65535)) - 32768;
      run_small(1, 1, r[0]);
    end

    begin
      int k = 0;
      int guard = 0;
      while (k < 2 && guard < 50) begin
        @(negedge clk);
        guard++;
        s_in_valid = 1'b1;
        s_in_data  = {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))};
        if (s_in_ready) k++;
      end
      check_value("partial_sent", k, 2);
    end
    @(negedge clk);
    s_in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    set_frame(1, 2, 3, 6, 5, 5, 5, 5);
    run_small(0, 0, 0);

    run_big();

    check_value("ready_while_busy", busy_ready_viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
